// File: rtl/mem_responder_if.sv
// Processor-to-memory handshake bundle: request side driven by the master,
// completion/data side driven by the memory responder.
interface mem_responder_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              cs;
    logic              read_req;
    logic              write_req;
    logic [ADDR_W-1:0] addrout;
    logic [DATA_W-1:0] datatomem;
    logic [DATA_W-1:0] datafrommem;
    logic              mem_resp;
    logic              req_err;

    modport master (
        output cs, read_req, write_req, addrout, datatomem,
        input  datafrommem, mem_resp, req_err
    );

    modport slave (
        input  cs, read_req, write_req, addrout, datatomem,
        output datafrommem, mem_resp, req_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word RAM responder with fixed access latency, one outstanding
// request at a time, flagging illegal and out-of-range requests.
module mem_responder #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    mem_responder_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int              IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT  = 4'(LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] read_q;
    logic              err_q;
    logic              in_range;
    logic              finishing;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] ram [DEPTH];

    assign in_range  = ({1'b0, addr_q} < DEPTH_LIM);
    assign idx       = addr_q[IDX_W-1:0];
    assign finishing = (state == WAIT) && (cnt == 4'd0);

    assign bus.mem_resp    = (state == RESP);
    assign bus.datafrommem = read_q;
    assign bus.req_err     = err_q;

    // The accepting edge only latches the request; WAIT always lasts at least
    // one cycle so the RESP cycle lands exactly LATENCY edges after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            op_write <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            read_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cs && (bus.read_req ^ bus.write_req)) begin
                        op_write <= bus.write_req;
                        addr_q   <= bus.addrout;
                        data_q   <= bus.datatomem;
                        cnt      <= CNT_INIT;
                        state    <= WAIT;
                    end else if (bus.cs && bus.read_req && bus.write_req) begin
                        err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        err_q <= !in_range;
                        if (!op_write) begin
                            read_q <= in_range ? ram[idx] : '0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Kept free of reset so it maps onto plain RAM; an aborted access never
    // reaches the finishing edge because reset forces the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (finishing && op_write && in_range) begin
            ram[idx] <= data_q;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: two instances (latency 2
// and latency 1) compared against an address-indexed reference memory.
module tb_mem_responder;
    logic clk;
    logic reset_n;

    logic        req_cs;
    logic        req_rd;
    logic        req_wr;
    logic [13:0] req_addr;
    logic [15:0] req_data;
    logic        use_l1;

    logic        obs_resp;
    logic [15:0] obs_data;
    logic        obs_err;

    int n_checks;
    int n_pass;

    logic [15:0] model_l2 [int];
    logic [15:0] model_l1 [int];
    logic [15:0] last_l2;
    logic [15:0] last_l1;

    mem_responder_if #(.ADDR_W(14), .DATA_W(16)) bus_l2 ();
    mem_responder_if #(.ADDR_W(14), .DATA_W(16)) bus_l1 ();

    assign bus_l2.cs        = req_cs & ~use_l1;
    assign bus_l2.read_req  = req_rd;
    assign bus_l2.write_req = req_wr;
    assign bus_l2.addrout   = req_addr;
    assign bus_l2.datatomem = req_data;

    assign bus_l1.cs        = req_cs & use_l1;
    assign bus_l1.read_req  = req_rd;
    assign bus_l1.write_req = req_wr;
    assign bus_l1.addrout   = req_addr;
    assign bus_l1.datatomem = req_data;

    assign obs_resp = use_l1 ? bus_l1.mem_resp    : bus_l2.mem_resp;
    assign obs_data = use_l1 ? bus_l1.datafrommem : bus_l2.datafrommem;
    assign obs_err  = use_l1 ? bus_l1.req_err     : bus_l2.req_err;

    mem_responder #(.ADDR_W(14), .DATA_W(16), .DEPTH(1024), .LATENCY(2)) dut_l2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_l2.slave)
    );

    mem_responder #(.ADDR_W(14), .DATA_W(16), .DEPTH(1024), .LATENCY(1)) dut_l1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_l1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at 1ns after a rising edge; returns with the request dropped and
    // the bench sitting 1ns into the IDLE cycle that follows the response.
    task automatic do_access(input bit wr, input logic [13:0] addr, input logic [15:0] data,
                             output logic [15:0] rdata, output int lat, output logic err);
        req_cs   = 1'b1;
        req_rd   = ~wr;
        req_wr   = wr;
        req_addr = addr;
        req_data = data;
        lat      = -1;
        rdata    = '0;
        err      = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            if (obs_resp) begin
                lat   = k;
                rdata = obs_data;
                err   = obs_err;
                break;
            end
            @(posedge clk); #1;
        end
        req_cs = 1'b0;
        req_rd = 1'b0;
        req_wr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        req_cs   = 1'b0;
        req_rd   = 1'b0;
        req_wr   = 1'b0;
        req_addr = '0;
        req_data = '0;
        use_l1   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus_l2.datafrommem !== 16'h0) $display("[TB] FAIL reset_data_l2: got %h expected 0000", bus_l2.datafrommem);
        else n_pass++;
        n_checks++;
        if (bus_l2.mem_resp !== 1'b0) $display("[TB] FAIL reset_resp_l2: got %b expected 0", bus_l2.mem_resp);
        else n_pass++;
        n_checks++;
        if (bus_l2.req_err !== 1'b0) $display("[TB] FAIL reset_err_l2: got %b expected 0", bus_l2.req_err);
        else n_pass++;
        n_checks++;
        if (bus_l1.datafrommem !== 16'h0) $display("[TB] FAIL reset_data_l1: got %h expected 0000", bus_l1.datafrommem);
        else n_pass++;
        n_checks++;
        if (bus_l1.mem_resp !== 1'b0) $display("[TB] FAIL reset_resp_l1: got %b expected 0", bus_l1.mem_resp);
        else n_pass++;
        n_checks++;
        if (bus_l1.req_err !== 1'b0) $display("[TB] FAIL reset_err_l1: got %b expected 0", bus_l1.req_err);
        else n_pass++;
        reset_n = 1'b1;
        last_l2 = 16'h0;
        last_l1 = 16'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] rd;
        int          lat;
        logic        err;
        use_l1 = 1'b0;
        do_access(1'b1, 14'h0005, 16'hBEEF, rd, lat, err);
        model_l2[5] = 16'hBEEF;
        n_checks++;
        if (lat !== 2) $display("[TB] FAIL basic_wr_latency: got %0d expected 2", lat);
        else n_pass++;
        n_checks++;
        if (rd !== last_l2) $display("[TB] FAIL basic_wr_data_held: got %h expected %h", rd, last_l2);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("[TB] FAIL basic_wr_err: got %b expected 0", err);
        else n_pass++;
        do_access(1'b0, 14'h0005, 16'h0000, rd, lat, err);
        last_l2 = model_l2[5];
        n_checks++;
        if (lat !== 2) $display("[TB] FAIL basic_rd_latency: got %0d expected 2", lat);
        else n_pass++;
        n_checks++;
        if (rd !== 16'hBEEF) $display("[TB] FAIL basic_rd_data: got %h expected beef", rd);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("[TB] FAIL basic_rd_err: got %b expected 0", err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int          lat_w;
        int          lat_r;
        int          pulses;
        logic [15:0] rd;
        use_l1   = 1'b0;
        lat_w    = -1;
        lat_r    = -1;
        rd       = '0;
        req_cs   = 1'b1;
        req_wr   = 1'b1;
        req_rd   = 1'b0;
        req_addr = 14'h0000;
        req_data = 16'h1234;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            if (obs_resp) begin
                lat_w = k;
                break;
            end
            @(posedge clk); #1;
        end
        req_wr = 1'b0;
        req_rd = 1'b1;
        model_l2[0] = 16'h1234;
        n_checks++;
        if (lat_w !== 2) $display("[TB] FAIL b2b_wr_latency: got %0d expected 2", lat_w);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (obs_resp !== 1'b0) $display("[TB] FAIL b2b_idle_gap: got %b expected 0", obs_resp);
        else n_pass++;
        @(posedge clk); #1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (obs_resp) begin
                lat_r = k;
                rd    = obs_data;
                pulses++;
                break;
            end
            @(posedge clk); #1;
        end
        req_cs = 1'b0;
        req_rd = 1'b0;
        last_l2 = model_l2[0];
        n_checks++;
        if (lat_r !== 2) $display("[TB] FAIL b2b_rd_latency: got %0d expected 2", lat_r);
        else n_pass++;
        n_checks++;
        if (rd !== 16'h1234) $display("[TB] FAIL b2b_rd_data: got %h expected 1234", rd);
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (obs_resp) pulses++;
        end
        n_checks++;
        if (pulses !== 1) $display("[TB] FAIL b2b_resp_count: got %0d expected 1", pulses);
        else n_pass++;
    endtask

    task automatic test_illegal();
        int          err_pulses;
        int          resp_pulses;
        logic [15:0] rd;
        int          lat;
        logic        err;
        use_l1   = 1'b0;
        req_cs   = 1'b1;
        req_rd   = 1'b1;
        req_wr   = 1'b1;
        req_addr = 14'h0000;
        req_data = 16'hFFFF;
        @(posedge clk); #1;
        req_cs = 1'b0;
        req_rd = 1'b0;
        req_wr = 1'b0;
        n_checks++;
        if (obs_err !== 1'b1) $display("[TB] FAIL illegal_err_pulse: got %b expected 1", obs_err);
        else n_pass++;
        n_checks++;
        if (obs_resp !== 1'b0) $display("[TB] FAIL illegal_no_resp: got %b expected 0", obs_resp);
        else n_pass++;
        err_pulses  = 0;
        resp_pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (obs_err) err_pulses++;
            if (obs_resp) resp_pulses++;
        end
        n_checks++;
        if (err_pulses !== 0) $display("[TB] FAIL illegal_err_single: got %0d extra expected 0", err_pulses);
        else n_pass++;
        n_checks++;
        if (resp_pulses !== 0) $display("[TB] FAIL illegal_late_resp: got %0d expected 0", resp_pulses);
        else n_pass++;
        do_access(1'b0, 14'h0000, 16'h0000, rd, lat, err);
        last_l2 = model_l2[0];
        n_checks++;
        if (rd !== model_l2[0]) $display("[TB] FAIL illegal_ram_kept: got %h expected %h", rd, model_l2[0]);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [15:0] rd;
        int          lat;
        logic        err;
        use_l1 = 1'b0;
        do_access(1'b0, 14'h3FFF, 16'h0000, rd, lat, err);
        last_l2 = 16'h0000;
        n_checks++;
        if (lat !== 2) $display("[TB] FAIL oor_rd_latency: got %0d expected 2", lat);
        else n_pass++;
        n_checks++;
        if (rd !== 16'h0000) $display("[TB] FAIL oor_rd_data: got %h expected 0000", rd);
        else n_pass++;
        n_checks++;
        if (err !== 1'b1) $display("[TB] FAIL oor_rd_err: got %b expected 1", err);
        else n_pass++;
        do_access(1'b1, 14'h0400, 16'h5555, rd, lat, err);
        n_checks++;
        if (err !== 1'b1) $display("[TB] FAIL oor_wr_err: got %b expected 1", err);
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("[TB] FAIL oor_wr_latency: got %0d expected 2", lat);
        else n_pass++;
        do_access(1'b0, 14'h0000, 16'h0000, rd, lat, err);
        last_l2 = model_l2[0];
        n_checks++;
        if (rd !== model_l2[0]) $display("[TB] FAIL oor_wr_discarded: got %h expected %h", rd, model_l2[0]);
        else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("[TB] FAIL oor_inrange_err: got %b expected 0", err);
        else n_pass++;
    endtask

    task automatic test_random_l2();
        logic [13:0] a;
        logic [15:0] d;
        logic [15:0] rd;
        logic [15:0] exp_d;
        int          lat;
        logic        err;
        bit          wr;
        bit          oor;
        use_l1 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            oor = ($urandom_range(0, 7) == 0);
            wr  = ($urandom_range(0, 1) == 1);
            a   = oor ? 14'($urandom_range(1024, 16383)) : 14'($urandom_range(0, 31));
            if (!wr && !oor && !model_l2.exists(int'(a))) wr = 1'b1;
            d = 16'($urandom);
            do_access(wr, a, d, rd, lat, err);
            if (wr) begin
                exp_d = last_l2;
                if (!oor) model_l2[int'(a)] = d;
            end else begin
                exp_d   = oor ? 16'h0000 : model_l2[int'(a)];
                last_l2 = exp_d;
            end
            n_checks++;
            if (lat !== 2) $display("[TB] FAIL rand_l2_latency[%0d]: got %0d expected 2", i, lat);
            else n_pass++;
            n_checks++;
            if (rd !== exp_d) $display("[TB] FAIL rand_l2_data[%0d] addr %h: got %h expected %h", i, a, rd, exp_d);
            else n_pass++;
            n_checks++;
            if (err !== oor) $display("[TB] FAIL rand_l2_err[%0d]: got %b expected %b", i, err, oor);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] rd;
        int          lat;
        logic        err;
        int          pulses;
        use_l1 = 1'b0;
        do_access(1'b1, 14'h0007, 16'h1111, rd, lat, err);
        model_l2[7] = 16'h1111;
        do_access(1'b0, 14'h0007, 16'h0000, rd, lat, err);
        req_cs   = 1'b1;
        req_wr   = 1'b1;
        req_addr = 14'h0007;
        req_data = 16'hAAAA;
        @(posedge clk); #1;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus_l2.datafrommem !== 16'h0000) $display("[TB] FAIL abort_data_zero: got %h expected 0000", bus_l2.datafrommem);
        else n_pass++;
        n_checks++;
        if (bus_l2.mem_resp !== 1'b0) $display("[TB] FAIL abort_resp_zero: got %b expected 0", bus_l2.mem_resp);
        else n_pass++;
        n_checks++;
        if (bus_l2.req_err !== 1'b0) $display("[TB] FAIL abort_err_zero: got %b expected 0", bus_l2.req_err);
        else n_pass++;
        @(posedge clk); #1;
        req_cs  = 1'b0;
        req_wr  = 1'b0;
        reset_n = 1'b1;
        last_l2 = 16'h0000;
        last_l1 = 16'h0000;
        pulses  = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (bus_l2.mem_resp) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("[TB] FAIL abort_no_resp: got %0d expected 0", pulses);
        else n_pass++;
        do_access(1'b0, 14'h0007, 16'h0000, rd, lat, err);
        last_l2 = model_l2[7];
        n_checks++;
        if (rd !== 16'h1111) $display("[TB] FAIL abort_write_dropped: got %h expected 1111", rd);
        else n_pass++;
    endtask

    task automatic test_latency1_sweep();
        logic [13:0] a;
        logic [15:0] d;
        logic [15:0] rd;
        logic [15:0] exp_d;
        int          lat;
        logic        err;
        bit          wr;
        use_l1 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            d = 16'($urandom);
            do_access(1'b1, 14'(i), d, rd, lat, err);
            model_l1[i] = d;
            n_checks++;
            if (lat !== 1) $display("[TB] FAIL l1_fill_latency[%0d]: got %0d expected 1", i, lat);
            else n_pass++;
        end
        for (int i = 0; i < 32; i++) begin
            wr = ($urandom_range(0, 1) == 1);
            a  = 14'($urandom_range(0, 15));
            d  = 16'($urandom);
            do_access(wr, a, d, rd, lat, err);
            if (wr) begin
                exp_d = last_l1;
                model_l1[int'(a)] = d;
            end else begin
                exp_d   = model_l1[int'(a)];
                last_l1 = exp_d;
            end
            n_checks++;
            if (lat !== 1) $display("[TB] FAIL l1_latency[%0d]: got %0d expected 1", i, lat);
            else n_pass++;
            n_checks++;
            if (rd !== exp_d) $display("[TB] FAIL l1_data[%0d] addr %h: got %h expected %h", i, a, rd, exp_d);
            else n_pass++;
        end
        use_l1 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_out_of_range();
        test_random_l2();
        test_reset_abort();
        test_latency1_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
